// File: rtl/mips_pkg.sv
// Shared MIPS encodings and pipeline-controller types.
// Opcodes follow this core's custom encoding, not the standard MIPS one.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b011001;
    localparam logic [5:0] OP_LW    = 6'b101111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_ADDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_JMP   = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_MUL   = 6'b110010;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_decode.sv
// Register-usage decoder: which architectural registers an instruction reads
// and writes, plus load/MUL class flags. Purely combinational.
module reg_use_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  src1_o,
    output logic [4:0]  src2_o,
    output logic [4:0]  dst_o,
    output logic        src1_use_o,
    output logic        src2_use_o,
    output logic        dst_use_o,
    output logic        is_load_o,
    output logic        is_mul_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode       = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign unused_shamt = ^instr_i[10:6];

    always_comb begin
        src1_o     = instr_i[25:21];
        src2_o     = instr_i[20:16];
        dst_o      = '0;
        src1_use_o = 1'b0;
        src2_use_o = 1'b0;
        dst_use_o  = 1'b0;
        is_load_o  = 1'b0;
        is_mul_o   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                src1_use_o = 1'b1;
                src2_use_o = 1'b1;
                dst_o      = instr_i[15:11];
                dst_use_o  = 1'b1;
                is_mul_o   = (funct == FN_MUL);
            end
            OP_LW: begin
                src1_use_o = 1'b1;
                dst_o      = instr_i[20:16];
                dst_use_o  = 1'b1;
                is_load_o  = 1'b1;
            end
            OP_ADDI, OP_ORI: begin
                src1_use_o = 1'b1;
                dst_o      = instr_i[20:16];
                dst_use_o  = 1'b1;
            end
            OP_SW, OP_BNE: begin
                src1_use_o = 1'b1;
                src2_use_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle MUL occupancy
// of EX, branch/jump squashing and a saturating stall counter.
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_branch_taken,
    input  logic             id_jmp,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_state_e      state_q, state_d;
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic             ex_valid_q, ex_valid_d;
    logic             ex_is_load_q, ex_is_load_d;
    logic [4:0]       ex_dst_q, ex_dst_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0] src1, src2, dst;
    logic       src1_use, src2_use, dst_use, is_load, is_mul;
    logic       load_use;

    reg_use_decode u_decode (
        .instr_i    (id_instr),
        .src1_o     (src1),
        .src2_o     (src2),
        .dst_o      (dst),
        .src1_use_o (src1_use),
        .src2_use_o (src2_use),
        .dst_use_o  (dst_use),
        .is_load_o  (is_load),
        .is_mul_o   (is_mul)
    );

    assign load_use = ex_valid_q & ex_is_load_q & id_valid & (ex_dst_q != 5'd0) &
                      ((src1_use & (src1 == ex_dst_q)) | (src2_use & (src2 == ex_dst_q)));

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        mul_busy     = 1'b0;
        state_d      = state_q;
        mul_cnt_d    = mul_cnt_q;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
        end else if (state_q == ST_MUL_WAIT) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            mul_busy     = 1'b1;
            mul_cnt_d    = mul_cnt_q - 4'd1;
            if (mul_cnt_q == 4'd1) begin
                state_d = ST_RUN;
            end
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jmp & id_valid) begin
            ifid_flush = 1'b1;
        end

        // A MUL only occupies EX if it actually entered ID/EX unsquashed.
        if (!rst && state_q == ST_RUN && idex_en && !idex_flush && id_valid && is_mul &&
            MUL_CYCLES > 1) begin
            state_d   = ST_MUL_WAIT;
            mul_cnt_d = 4'(MUL_CYCLES - 1);
        end

        ex_valid_d   = ex_valid_q;
        ex_is_load_d = ex_is_load_q;
        ex_dst_d     = ex_dst_q;
        if (idex_en) begin
            if (idex_flush || !id_valid) begin
                ex_valid_d   = 1'b0;
                ex_is_load_d = 1'b0;
                ex_dst_d     = '0;
            end else begin
                ex_valid_d   = 1'b1;
                ex_is_load_d = is_load;
                ex_dst_d     = dst_use ? dst : 5'd0;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!rst && !pc_en && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            mul_cnt_q    <= '0;
            ex_valid_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_dst_q     <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mul_cnt_q    <= mul_cnt_d;
            ex_valid_q   <= ex_valid_d;
            ex_is_load_q <= ex_is_load_d;
            ex_dst_q     <= ex_dst_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors with
// hand-computed control outputs and stall counts.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 16;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, mul_busy}
    localparam logic [6:0] C_NORM = 7'b1101000;
    localparam logic [6:0] C_RST  = 7'b0111110;
    localparam logic [6:0] C_LU   = 7'b0001100;
    localparam logic [6:0] C_BR   = 7'b1111100;
    localparam logic [6:0] C_JMP  = 7'b1111000;
    localparam logic [6:0] C_MULW = 7'b0000011;

    localparam logic [31:0] I_NOP   = 32'd0;
    localparam logic [31:0] I_LW1   = 32'b101111_00000_00001_0000000000000000;
    localparam logic [31:0] I_LW0   = 32'b101111_00000_00000_0000000000000000;
    localparam logic [31:0] I_ADD   = 32'b011001_00001_00010_00110_01010_100000;
    localparam logic [31:0] I_ADDR0 = 32'b011001_00000_00000_00110_00000_100000;
    localparam logic [31:0] I_ORI30 = 32'b110011_00000_11110_0000000000000101;
    localparam logic [31:0] I_MUL   = 32'b011001_00001_00010_00011_01010_110010;
    localparam logic [31:0] I_JMP   = 32'b000010_000000_0000_0011_0011_1010_1111;

    typedef struct packed {
        logic [6:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [7:0]       cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             ex_branch_taken;
    logic             id_jmp;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_bubble, mul_busy;
    logic [CNT_W-1:0] stall_count;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    pipeline_ctrl #(
        .MUL_CYCLES (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_instr        (id_instr),
        .id_valid        (id_valid),
        .ex_branch_taken (ex_branch_taken),
        .id_jmp          (id_jmp),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_bubble    (exmem_bubble),
        .mul_busy        (mul_busy),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic br,
                        input logic [6:0] ctl, input int unsigned sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        id_instr        = ins;
        id_valid        = v;
        ex_branch_taken = br;
        id_jmp          = (ins[31:26] == 6'b000010);
        e.ctl = ctl;
        e.sc  = CNT_W'(sc);
        e.cyc = 8'(cyc);
        exp_q.push_back(e);
        cyc++;
    endtask

    // Monitor: the controller presents a full output set every cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t     e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, mul_busy};
            n_cmp++;
            if (got !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl cyc%0d got %b exp %b", e.cyc, got, e.ctl);
            end
            n_cmp++;
            if (stall_count !== e.sc) begin
                n_fail++;
                $display("FAIL stall_count cyc%0d got %0d exp %0d", e.cyc, stall_count, e.sc);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        id_instr        = I_NOP;
        id_valid        = 1'b0;
        ex_branch_taken = 1'b0;
        id_jmp          = 1'b0;

        step(1, I_NOP,   0, 0, C_RST,  0);   // 0  reset
        step(1, I_NOP,   0, 0, C_RST,  0);   // 1
        step(0, I_LW1,   1, 0, C_NORM, 0);   // 2  LW r1
        step(0, I_ADD,   1, 0, C_LU,   0);   // 3  load-use
        step(0, I_ADD,   1, 0, C_NORM, 1);   // 4  retry
        step(0, I_LW1,   1, 0, C_NORM, 1);   // 5
        step(0, I_ORI30, 1, 0, C_NORM, 1);   // 6  independent
        step(0, I_LW0,   1, 0, C_NORM, 1);   // 7  LW r0
        step(0, I_ADDR0, 1, 0, C_NORM, 1);   // 8  reads r0: no hazard
        step(0, I_MUL,   1, 0, C_NORM, 1);   // 9  MUL enters EX
        step(0, I_ORI30, 1, 0, C_MULW, 1);   // 10
        step(0, I_ORI30, 1, 0, C_MULW, 2);   // 11
        step(0, I_ORI30, 1, 0, C_MULW, 3);   // 12
        step(0, I_ORI30, 1, 0, C_NORM, 4);   // 13
        step(0, I_ADD,   1, 1, C_BR,   4);   // 14 taken branch
        step(0, I_LW1,   1, 0, C_NORM, 4);   // 15
        step(0, I_ADD,   1, 1, C_BR,   4);   // 16 branch beats load-use
        step(0, I_JMP,   1, 0, C_JMP,  4);   // 17 jump
        step(0, I_NOP,   1, 0, C_NORM, 4);   // 18
        step(0, I_LW1,   1, 0, C_NORM, 4);   // 19
        step(0, I_ADD,   0, 0, C_NORM, 4);   // 20 invalid: no check
        step(0, I_ADD,   1, 0, C_NORM, 4);   // 21 shadow holds bubble
        step(0, I_MUL,   1, 0, C_NORM, 4);   // 22
        step(0, I_ORI30, 1, 0, C_MULW, 4);   // 23
        step(1, I_ORI30, 1, 0, C_RST,  5);   // 24 reset mid-MUL
        step(0, I_NOP,   1, 0, C_NORM, 0);   // 25
        step(0, I_MUL,   1, 0, C_NORM, 0);   // 26
        step(0, I_NOP,   1, 0, C_MULW, 0);   // 27
        step(0, I_NOP,   1, 0, C_MULW, 1);   // 28
        step(0, I_NOP,   1, 0, C_MULW, 2);   // 29
        step(0, I_NOP,   1, 0, C_NORM, 3);   // 30

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left %0d exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the `control` decoder and watches the instruction in ID plus its own shadow of EX/MEM occupancy. It drives PC and pipeline-register enables, bubbles and flushes for three cases: load-use hazards, multi-cycle MUL occupancy of EX, and control transfers (JMP in ID, taken BNE in EX). It also keeps a saturating stall counter for performance checks.

## Interface
Parameters:
- `MUL_CYCLES`, 4: cycles a MUL occupies EX; legal range 1..15.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  system clock. One clock; everything is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_instr`  in  32  instruction currently in the IF/ID register.
- `id_valid`  in  1  IF/ID holds a real instruction, not a bubble.
- `ex_branch_taken`  in  1  BNE in EX resolved taken this cycle.
- `id_jmp`  in  1  `jmpFlag` from `control` for `id_instr`.
- `pc_en`  out  1  PC may update.
- `ifid_en`  out  1  IF/ID may load.
- `ifid_flush`  out  1  IF/ID loads a NOP (32'd0) at the next edge.
- `idex_en`  out  1  ID/EX may load.
- `idex_flush`  out  1  ID/EX loads a bubble at the next edge.
- `exmem_bubble`  out  1  EX/MEM loads a bubble, because EX is still computing a MUL.
- `mul_busy`  out  1  FSM is in MUL_WAIT.
- `stall_count`  out  CNT_W  number of stall cycles; saturates at all-ones.

## Operation
- Field decode of `id_instr`:
  - R-type (opcode 011001): sources rs, rt; destination rd [15:11]; MUL when funct = 110010.
  - LW 101111, ADDI 110010, ORI 110011: source rs; destination rt [20:16].
  - SW 110000 and BNE 110001: sources rs, rt; no destination.
  - JMP 000010 and NOP: no sources, no destination.
  - Register 0 is never a dependency.
- Shadow state, updated when ID/EX loads:
  - `ex_valid`, `ex_is_load`, `ex_dst`.
  - A flushed or bubbled load writes `ex_valid`=0.
- Load-use stall:
  - Condition: `ex_valid & ex_is_load & id_valid` and `ex_dst` ≠ 0 matches any source of `id_instr`.
  - Action: `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for exactly one cycle.
- FSM states: RUN and MUL_WAIT.
  - RUN → MUL_WAIT when a valid MUL loads into ID/EX and MUL_CYCLES > 1. `mul_cnt` loads MUL_CYCLES−1.
  - In MUL_WAIT: `pc_en`=`ifid_en`=`idex_en`=0 and `exmem_bubble`=1. `mul_cnt` decrements each cycle.
  - MUL_WAIT → RUN in the cycle `mul_cnt`=1; that cycle still stalls.
- Taken branch (`ex_branch_taken`): `ifid_flush`=1 and `idex_flush`=1; PC updates.
- Jump (`id_jmp & id_valid`): `ifid_flush`=1 only; PC updates.
- Priority, highest first: `rst` > MUL_WAIT > branch taken > load-use > jump > normal flow.
  - A load-use stall hides a simultaneous jump. The jump is taken on the retry cycle.
- Normal flow: all enables 1, all flush/bubble outputs 0.
- `stall_count` increments in every cycle where `pc_en`=0 and `rst`=0, saturating at 2^CNT_W−1.

## Timing
- Enable, flush and bubble outputs are combinational from the inputs and registered state. They take effect at the next rising edge.
- Load-use penalty: 1 cycle. Branch penalty: 2 squashed instructions. Jump penalty: 1 squashed instruction.
- MUL penalty: MUL_CYCLES−1 stall cycles. With MUL_CYCLES=1 there is no stall and the FSM stays in RUN.
- While `rst`=1:
  - Outputs: `pc_en`=0, `ifid_en`=1, `ifid_flush`=1, `idex_en`=1, `idex_flush`=1, `exmem_bubble`=1, `mul_busy`=0.
  - Edge clears: state → RUN, `mul_cnt`=0, `ex_valid`=0, `stall_count`=0.
- Reset asserted mid-MUL_WAIT: FSM returns to RUN at that edge and the MUL is discarded.
- `id_valid`=0: no hazard checks run, and the shadow state records a bubble.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_ADDI, OP_ORI, OP_JMP.
  - Funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_MUL.
  - The FSM state enum.
- One sub-module, `reg_use_decode`: purely combinational. It maps `id_instr` to `src1`/`src2`/`dst`, their use flags, `is_load` and `is_mul`. `control` can reuse it later.
- `pipeline_ctrl` itself holds the FSM, `mul_cnt`, the shadow registers and `stall_count`.

## Test plan
- Load-use: LW 32'b101111_00000_00001_0…0, then ADD with rs=1 (32'b011001_00001_00010_00110_01010_100000).
  - Expect one cycle of `pc_en`=0 and `idex_flush`=1, then normal flow; `stall_count`=1.
- Load with no dependency: LW rt=1, then ORI 32'b110011_00000_11110_…, rt=30, rs=0.
  - Expect no stall.
  - Repeat with LW rt=0 and a consumer of r0: expect no stall.
- MUL with MUL_CYCLES=4: issue MUL 32'b011001_00001_00010_00011_01010_110010.
  - Expect `mul_busy`=1 and `exmem_bubble`=1 for 3 cycles, then RUN; `stall_count`=3.
- Taken BNE: pulse `ex_branch_taken`.
  - Expect `ifid_flush`=`idex_flush`=1 for one cycle with `pc_en`=1.
  - Apply the pulse together with a load-use condition: only the flush occurs and there is no stall.
- JMP 32'b000010_000000_0000_0011_0011_1010_1111 in ID: expect `ifid_flush`=1 for one cycle and no `idex_flush`.
- Reset: assert `rst` in the second MUL_WAIT cycle.
  - Expect `mul_busy`=0 after the edge and `stall_count`=0.
  - After `rst` falls, the next MUL again stalls 3 cycles.
